// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer port arbiter: width defaults,
// grant-state encoding and a saturating counter helper.
package fb_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } grant_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Write queue for the framebuffer arbiter. Full/empty come from registered
// occupancy only, so a pop never frees a slot for a push in the same cycle.
module fb_wr_fifo #(
  parameter int W     = 30,
  parameter int DEPTH = 4
) (
  input  logic         clk_16mhz,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_16mhz) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_16mhz) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// SPRAM port arbiter: video reads have absolute priority, dither writes are
// queued and drained in idle slots. Statistics counters need FB_ARB_STATS_EN.
//
// state | meaning
// IDLE  | no RAM operation this cycle (ram_wen=0, ram_addr=0)
// READ  | video read granted, data returns next cycle
// WRITE | queue head issued to the RAM
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              clk_16mhz,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       drop_count,
  output logic [15:0]       preempt_count
);

  grant_t              grant;
  grant_t              grant_q;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_data;
  logic [DATA_W-1:0]   rd_hold;

  always_comb begin
    grant = IDLE;
    if (!reset) begin
      if (rd_req)           grant = READ;
      else if (!fifo_empty) grant = WRITE;
    end
  end

  assign fifo_push = wr_req & ~fifo_full & ~reset;
  assign fifo_pop  = (grant == WRITE);
  assign wr_ready  = ~fifo_full;

  fb_wr_fifo #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (WFIFO_DEPTH)
  ) u_wr_fifo (
    .clk_16mhz (clk_16mhz),
    .reset     (reset),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .din       ({wr_addr, wr_data}),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .dout      ({head_addr, head_data})
  );

  always_comb begin
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (grant)
      READ: ram_addr = rd_addr;
      WRITE: begin
        ram_wen   = 1'b1;
        ram_addr  = head_addr;
        ram_wdata = head_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_16mhz) begin
    if (reset) begin
      grant_q <= IDLE;
      rd_hold <= '0;
    end else begin
      grant_q <= grant;
      if (grant_q == READ) rd_hold <= ram_rdata;
    end
  end

  // Gating with reset suppresses a read return that lands in the reset cycle.
  assign rd_valid = (grant_q == READ) & ~reset;
  assign rd_data  = reset ? '0 : ((grant_q == READ) ? ram_rdata : rd_hold);

`ifdef FB_ARB_STATS_EN
  logic [15:0] drop_cnt_q;
  logic [15:0] preempt_cnt_q;

  always_ff @(posedge clk_16mhz) begin
    if (reset) begin
      drop_cnt_q    <= '0;
      preempt_cnt_q <= '0;
    end else begin
      if (wr_req && fifo_full)
        drop_cnt_q <= sat_inc16(drop_cnt_q);
      if (grant == READ && !fifo_empty)
        preempt_cnt_q <= sat_inc16(preempt_cnt_q);
    end
  end

  assign drop_count    = drop_cnt_q;
  assign preempt_count = preempt_cnt_q;
`else
  assign drop_count    = '0;
  assign preempt_count = '0;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter: stimulus pushes expected reads and
// writes, a negedge monitor pops and compares them against what the DUT emits.
module tb_fb_port_arbiter;

  localparam int AW    = 14;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk_16mhz = 1'b0;
  logic          reset;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [15:0]   drop_count;
  logic [15:0]   preempt_count;

  always #5 clk_16mhz = ~clk_16mhz;

  fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WFIFO_DEPTH(DEPTH)) dut (
    .clk_16mhz     (clk_16mhz),
    .reset         (reset),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .ram_wen       (ram_wen),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata),
    .drop_count    (drop_count),
    .preempt_count (preempt_count)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int            errors = 0;
  int            checks = 0;
  wr_t           exp_wr[$];
  logic [DW-1:0] exp_rd[$];
  int            mcnt = 0;
  int            exp_drop = 0;
  int            exp_pre = 0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {2'b10, a} ^ 16'h0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Synchronous SPRAM model: read data appears the cycle after the address.
  initial begin
    ram_rdata = '0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = pat(AW'(i));
    mem[14'h0123] = 16'hBEEF;
    forever begin
      @(posedge clk_16mhz);
      ram_rdata <= mem[ram_addr];
      if (ram_wen) mem[ram_addr] = ram_wdata;
    end
  end

  // Monitor
  initial begin
    logic          prev_rd;
    logic [DW-1:0] e;
    wr_t           w;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk_16mhz);
      if (reset) begin
        chk("reset_ram_wen", 32'(ram_wen), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        prev_rd = 1'b0;
      end else begin
        chk("rd_valid_timing", 32'(rd_valid), 32'(prev_rd));
        if (rd_valid) begin
          if (exp_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected actual=rd_valid data=%h required=no_read", rd_data);
          end else begin
            e = exp_rd.pop_front();
            chk("rd_data", 32'(rd_data), 32'(e));
          end
        end
        if (rd_req) begin
          chk("rd_grant_wen", 32'(ram_wen), 32'd0);
          chk("rd_grant_addr", 32'(ram_addr), 32'(rd_addr));
        end
        if (ram_wen) begin
          if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_unexpected actual=addr %h data %h required=no_write", ram_addr, ram_wdata);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", 32'(ram_addr), 32'(w.a));
            chk("wr_data", 32'(ram_wdata), 32'(w.d));
          end
        end
        prev_rd = rd_req;
      end
    end
  end

  // One cycle of stimulus; entered and left at posedge+1.
  task automatic step(input logic rd, input logic [AW-1:0] ra, input logic wr,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int nc;
    rd_req = rd; rd_addr = ra; wr_req = wr; wr_addr = wa; wr_data = wd;
    #1;
    chk("wr_ready", 32'(wr_ready), 32'(mcnt < DEPTH));
    chk("drop_count", 32'(drop_count), 32'(exp_drop));
    chk("preempt_count", 32'(preempt_count), 32'(exp_pre));
    if (rd) exp_rd.push_back((ra == 14'h0123) ? 16'hBEEF : pat(ra));
`ifdef FB_ARB_STATS_EN
    if (wr && mcnt == DEPTH && exp_drop < 65535) exp_drop++;
    if (rd && mcnt > 0 && exp_pre < 65535) exp_pre++;
`endif
    nc = mcnt;
    if (!rd && mcnt > 0) nc--;
    if (wr && mcnt < DEPTH) begin
      nc++;
      exp_wr.push_back({wa, wd});
    end
    mcnt = nc;
    @(posedge clk_16mhz); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0);
  endtask

  // Requests are held high through reset to show they are ignored.
  task automatic do_reset(input int n);
    reset = 1'b1; rd_req = 1'b1; rd_addr = 14'h0055; wr_req = 1'b1;
    wr_addr = 14'h3FFF; wr_data = 16'hDEAD;
    exp_wr.delete(); exp_rd.delete();
    mcnt = 0; exp_drop = 0; exp_pre = 0;
    repeat (n) begin @(posedge clk_16mhz); #1; end
    reset = 1'b0; rd_req = 1'b0; wr_req = 1'b0; rd_addr = '0;
    #1;
    chk("post_reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("post_reset_rd_data", 32'(rd_data), 32'd0);
    chk("post_reset_wr_ready", 32'(wr_ready), 32'd1);
    chk("post_reset_drop", 32'(drop_count), 32'd0);
    chk("post_reset_preempt", 32'(preempt_count), 32'd0);
    chk("post_reset_ram_wen", 32'(ram_wen), 32'd0);
    @(posedge clk_16mhz); #1;
  endtask

  initial begin
    reset = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    @(posedge clk_16mhz); #1;
    do_reset(2);

    // Isolated read
    step(1'b1, 14'h0123, 1'b0, '0, '0);
    rd_req = 1'b0; #1;
    chk("iso_rd_valid", 32'(rd_valid), 32'd1);
    chk("iso_rd_data", 32'(rd_data), 32'hBEEF);
    chk("iso_rd_wen", 32'(ram_wen), 32'd0);
    idle(2);

    // Isolated write, not bypassed into its own cycle
    rd_req = 1'b0; wr_req = 1'b1; wr_addr = 14'h0010; wr_data = 16'hA5A5; #1;
    chk("no_bypass", 32'(ram_wen), 32'd0);
    step(1'b0, '0, 1'b1, 14'h0010, 16'hA5A5);
    wr_req = 1'b0; #1;
    chk("iso_wr_wen", 32'(ram_wen), 32'd1);
    chk("iso_wr_addr", 32'(ram_addr), 32'h0010);
    chk("iso_wr_data", 32'(ram_wdata), 32'hA5A5);
    idle(2);

    // Collision: reads on cycles 1-3 hold off two queued writes
    step(1'b0, '0, 1'b1, 14'h2000, 16'h1111);
    step(1'b1, 14'h0200, 1'b1, 14'h2001, 16'h2222);
    step(1'b1, 14'h0201, 1'b0, '0, '0);
    step(1'b1, 14'h0202, 1'b0, '0, '0);
    idle(3);
`ifdef FB_ARB_STATS_EN
    chk("collision_preempt", 32'(preempt_count), 32'd3);
`else
    chk("collision_preempt", 32'(preempt_count), 32'd0);
`endif

    // Overflow: six writes under continuous reads
    do_reset(1);
    for (int i = 0; i < 6; i++)
      step(1'b1, AW'(14'h0300 + i), 1'b1, AW'(14'h2100 + i), DW'(16'h3000 + i));
    rd_req = 1'b0; wr_req = 1'b0; #1;
    chk("ovf_wr_ready", 32'(wr_ready), 32'd0);
`ifdef FB_ARB_STATS_EN
    chk("ovf_drop", 32'(drop_count), 32'd2);
`else
    chk("ovf_drop", 32'(drop_count), 32'd0);
`endif
    idle(6);

    // Reset with three writes pending
    for (int i = 0; i < 3; i++)
      step(1'b1, AW'(14'h0310 + i), 1'b1, AW'(14'h2200 + i), DW'(16'h5000 + i));
    do_reset(1);
    idle(5);

    // Video cadence: a read every 16th cycle against continuous writes
    for (int c = 0; c < 80; c++)
      step((c % 16) == 0, AW'(14'h0400 + c), 1'b1, AW'(14'h2400 + c), DW'(16'h4000 + c));
    idle(10);

    chk("final_wr_queue", 32'(exp_wr.size()), 32'd0);
    chk("final_rd_queue", 32'(exp_rd.size()), 32'd0);
    chk("final_wr_ready", 32'(wr_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
